// File: rtl/delay.sv
// -----------------------------------------------------------------------------
// delay : fixed-latency pipeline delay line for a data word.
//
// out(t) = in(t-DELAY). Short delays (1..SRL_MAX) are built as a register
// chain; longer delays use a circular buffer of DELAY-1 words followed by an
// output register, so the bulk of the storage can map to RAM.
//
// Parameters
//   WIDTH    data word width in bits
//   DELAY    latency in clk cycles, 0..1024 (0 = combinational pass-through)
//   SRL_MAX  largest DELAY built as a register chain
//
// Ports
//   clk      single clock, rising edge
//   rst_n    asynchronous active-low reset; forces out=0 (no effect at DELAY=0)
//   ce       clock enable, only present when DELAY_CE_EN is defined
//   in       data input, sampled every (enabled) rising edge
//   out      delayed data output
//
// Build option
//   DELAY_CE_EN  adds the ce port; ce=0 freezes the whole line, latency is
//                then counted in enabled edges.
// -----------------------------------------------------------------------------
module delay #(
  parameter int WIDTH   = 32,
  parameter int DELAY   = 1,
  parameter int SRL_MAX = 16
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef DELAY_CE_EN
  input  logic             ce,
`endif
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out
);

  logic adv;

`ifdef DELAY_CE_EN
  assign adv = ce;
`else
  assign adv = 1'b1;
`endif

  generate
    if (DELAY < 0 || DELAY > 1024) begin : g_illegal
      $error("delay: DELAY=%0d outside legal range 0..1024", DELAY);
      assign out = in;
    end else if (DELAY == 0) begin : g_comb
      assign out = in;
    end else if (DELAY <= SRL_MAX || DELAY == 1) begin : g_chain
      logic [WIDTH-1:0] chain_q [DELAY];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < DELAY; i++) chain_q[i] <= '0;
        end else if (adv) begin
          chain_q[0] <= in;
          for (int i = 1; i < DELAY; i++) chain_q[i] <= chain_q[i-1];
        end
      end

      assign out = chain_q[DELAY-1];
    end else begin : g_buf
      localparam int DEPTH = DELAY - 1;
      localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
      localparam int FW    = (DELAY > 1) ? $clog2(DELAY) : 1;
      localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
      localparam logic [FW-1:0] FILL_MAX = FW'(DEPTH);

      logic [WIDTH-1:0] mem [DEPTH];
      logic [PW-1:0]    ptr_q, ptr_d;
      logic [FW-1:0]    fill_q, fill_d;
      logic [WIDTH-1:0] out_q, out_d;
      logic             full;

      // The slot about to be overwritten holds the word written DELAY-1
      // enabled edges ago; once the buffer has filled, that word goes to the
      // output register, giving DELAY edges of total latency. Until then the
      // RAM contents are stale and the output register is loaded with zero.
      always_comb begin
        full   = (fill_q == FILL_MAX);
        ptr_d  = (ptr_q == PTR_LAST) ? '0 : ptr_q + PW'(1);
        fill_d = full ? fill_q : fill_q + FW'(1);
        out_d  = full ? mem[ptr_q] : '0;
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ptr_q  <= '0;
          fill_q <= '0;
          out_q  <= '0;
        end else if (adv) begin
          ptr_q  <= ptr_d;
          fill_q <= fill_d;
          out_q  <= out_d;
        end
      end

      // Storage is deliberately left unreset so it can map onto RAM.
      always_ff @(posedge clk) begin
        if (adv) mem[ptr_q] <= in;
      end

      assign out = out_q;
    end
  endgenerate

endmodule

// File: tb/tb_delay.sv
// -----------------------------------------------------------------------------
// tb_delay : directed self-checking bench for delay.
// Several instances with different DELAY values share clk, rst_n, ce and in.
// Stimulus is a counter (base + edge count since reset) so the expected
// output of every instance follows from the edge count alone.
// -----------------------------------------------------------------------------
`ifdef DELAY_CE_EN
  `define TB_CE_CONN .ce(ce),
`else
  `define TB_CE_CONN
`endif

module tb_delay;
  localparam int W  = 32;
  localparam int NI = 7;
  localparam int DLY [NI] = '{0, 1, 4, 8, 16, 17, 40};

  logic         clk = 1'b0;
  logic         rst_n;
  logic         ce;
  logic [W-1:0] in;
  logic [W-1:0] outs [NI];

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  delay #(.WIDTH(W), .DELAY(0))  u_d0  (.clk(clk), .rst_n(rst_n), `TB_CE_CONN .in(in), .out(outs[0]));
  delay #(.WIDTH(W), .DELAY(1))  u_d1  (.clk(clk), .rst_n(rst_n), `TB_CE_CONN .in(in), .out(outs[1]));
  delay #(.WIDTH(W), .DELAY(4))  u_d4  (.clk(clk), .rst_n(rst_n), `TB_CE_CONN .in(in), .out(outs[2]));
  delay #(.WIDTH(W), .DELAY(8))  u_d8  (.clk(clk), .rst_n(rst_n), `TB_CE_CONN .in(in), .out(outs[3]));
  delay #(.WIDTH(W), .DELAY(16)) u_d16 (.clk(clk), .rst_n(rst_n), `TB_CE_CONN .in(in), .out(outs[4]));
  delay #(.WIDTH(W), .DELAY(17)) u_d17 (.clk(clk), .rst_n(rst_n), `TB_CE_CONN .in(in), .out(outs[5]));
  delay #(.WIDTH(W), .DELAY(40)) u_d40 (.clk(clk), .rst_n(rst_n), `TB_CE_CONN .in(in), .out(outs[6]));

  // Expected output after c enabled edges of counter stimulus base+c.
  function automatic logic [W-1:0] exp_cnt(input int base, input int c, input int d);
    return (c >= d) ? W'(base + c - d) : '0;
  endfunction

  // Called at posedge+1; releases reset at posedge+1 so the next edge is edge 0.
  task automatic do_reset();
    rst_n = 1'b0;
    in    = $urandom;
    @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Counter stimulus right after reset release; checks every instance each cycle.
  task automatic run_stream(input string tag, input int base, input int ncyc);
    logic [W-1:0] exp;
    for (int c = 0; c < ncyc; c++) begin
      in = W'(base + c);
      @(negedge clk);
      for (int k = 0; k < NI; k++) begin
        exp = exp_cnt(base, c, DLY[k]);
        n_cmp++;
        if (outs[k] !== exp) begin
          n_mis++;
          $display("FAIL %s d%0d c=%0d: out=%h expected=%h", tag, DLY[k], c, outs[k], exp);
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    logic [W-1:0] exp;
    rst_n = 1'b0;
    ce    = 1'b1;
    in    = $urandom;
    #1;
    // No clock edge yet: zero output comes from the asynchronous reset alone.
    for (int k = 0; k < NI; k++) begin
      exp = (DLY[k] == 0) ? in : '0;
      n_cmp++;
      if (outs[k] !== exp) begin
        n_mis++;
        $display("FAIL reset_async d%0d: out=%h expected=%h", DLY[k], outs[k], exp);
      end
    end
    for (int cyc = 0; cyc < 4; cyc++) begin
      in = $urandom;
      @(negedge clk);
      for (int k = 0; k < NI; k++) begin
        exp = (DLY[k] == 0) ? in : '0;
        n_cmp++;
        if (outs[k] !== exp) begin
          n_mis++;
          $display("FAIL reset_hold d%0d cyc=%0d: out=%h expected=%h", DLY[k], cyc, outs[k], exp);
        end
      end
      @(posedge clk);
    end
    #1;
  endtask

  task automatic test_counter();
    do_reset();
    run_stream("counter", 100, 60);
  endtask

  task automatic test_buffer_wrap();
    // 40 fill edges plus well over three 39-entry pointer wraps.
    do_reset();
    run_stream("wrap", 1000, 170);
  endtask

  task automatic test_midstream_reset();
    logic [W-1:0] exp;
    do_reset();
    run_stream("pre_rst", 300, 20);
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < NI; k++) begin
      exp = (DLY[k] == 0) ? in : '0;
      n_cmp++;
      if (outs[k] !== exp) begin
        n_mis++;
        $display("FAIL mid_rst_drop d%0d: out=%h expected=%h", DLY[k], outs[k], exp);
      end
    end
    rst_n = 1'b1;
    // Buffer RAM still holds earlier data; it must stay hidden until refilled.
    run_stream("post_rst", 5000, 50);
  endtask

  task automatic test_comb_d0();
    in = 32'hDEADBEEF;
    #1;
    n_cmp++;
    if (outs[0] !== 32'hDEADBEEF) begin
      n_mis++;
      $display("FAIL comb_d0: out=%h expected=%h", outs[0], 32'hDEADBEEF);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (outs[0] !== 32'hDEADBEEF) begin
      n_mis++;
      $display("FAIL comb_d0_rst: out=%h expected=%h", outs[0], 32'hDEADBEEF);
    end
    in = 32'h1234_5678;
    #1;
    n_cmp++;
    if (outs[0] !== 32'h1234_5678) begin
      n_mis++;
      $display("FAIL comb_d0_rst2: out=%h expected=%h", outs[0], 32'h1234_5678);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

`ifdef DELAY_CE_EN
  task automatic test_ce();
    logic [W-1:0] exp;
    int n;
    do_reset();
    n = 0;
    for (int cyc = 0; cyc < 24; cyc++) begin
      ce = (cyc % 2 == 0);
      in = ce ? W'(100 + n) : W'($urandom);
      @(negedge clk);
      exp = exp_cnt(100, n, 4);
      n_cmp++;
      if (outs[2] !== exp) begin
        n_mis++;
        $display("FAIL ce_d4 cyc=%0d: out=%h expected=%h", cyc, outs[2], exp);
      end
      @(posedge clk);
      #1;
      if (ce) n++;
    end
    ce = 1'b1;
  endtask
`endif

  initial begin
    in = '0;
    test_reset();
    test_counter();
    test_buffer_wrap();
    test_midstream_reset();
    test_comb_d0();
`ifdef DELAY_CE_EN
    test_ce();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

`undef TB_CE_CONN
